// File: rtl/count_seq_pkg.sv
// rtl/count_seq_pkg.sv - shared state encoding and default widths for count_seq_checker
package count_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam int DEF_CNT_W  = 4;
    localparam int DEF_WRAP_W = 8;
    localparam int DEF_ERR_W  = 8;
    localparam int DEF_LOCK_N = 2;
    // good_run must hold values up to LOCK_N (max 7)
    localparam int GOOD_W     = 3;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/count_seq_checker.sv
// rtl/count_seq_checker.sv - counter sequence checker; COUNT_SEQ_ERR_LOG_EN adds first-error capture
module count_seq_checker
    import count_seq_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int WRAP_W = DEF_WRAP_W,
    parameter int ERR_W  = DEF_ERR_W,
    parameter int LOCK_N = DEF_LOCK_N
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic [CNT_W-1:0]  cnt_in,
    output logic              wrap_pulse,
    output logic              restart_pulse,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [ERR_W-1:0]  err_count,
    output logic              locked
`ifdef COUNT_SEQ_ERR_LOG_EN
    ,
    output logic [CNT_W-1:0]  err_exp,
    output logic [CNT_W-1:0]  err_act
`endif
);

    localparam logic [CNT_W-1:0] MAX = '1;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  prev;
    logic [CNT_W-1:0]  exp_val;
    logic [GOOD_W-1:0] good_run, good_nxt;
    logic              wrap_evt, restart_evt, err_evt;

    assign exp_val = prev + CNT_W'(1);
    assign locked  = (state == TRACK);

    always_comb begin
        state_nxt   = state;
        good_nxt    = good_run;
        wrap_evt    = 1'b0;
        restart_evt = 1'b0;
        err_evt     = 1'b0;
        if (en) begin
            case (state)
                IDLE: state_nxt = TRACK;
                TRACK: begin
                    if (cnt_in == exp_val) begin
                        wrap_evt = (prev == MAX);
                    end else if (cnt_in == '0) begin
                        restart_evt = 1'b1;
                    end else begin
                        err_evt   = 1'b1;
                        state_nxt = FAULT;
                        good_nxt  = '0;
                    end
                end
                FAULT: begin
                    // a MAX->0 step here only counts toward relock, never as a wrap
                    if (cnt_in == exp_val) begin
                        good_nxt = good_run + GOOD_W'(1);
                        if (good_nxt == GOOD_W'(LOCK_N)) begin
                            state_nxt = TRACK;
                        end
                    end else if (cnt_in == '0) begin
                        restart_evt = 1'b1;
                        good_nxt    = '0;
                    end else begin
                        err_evt  = 1'b1;
                        good_nxt = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            state         <= IDLE;
            prev          <= '0;
            good_run      <= '0;
            wrap_pulse    <= 1'b0;
            restart_pulse <= 1'b0;
            err_pulse     <= 1'b0;
            err_sticky    <= 1'b0;
        end else begin
            state         <= state_nxt;
            good_run      <= good_nxt;
            wrap_pulse    <= wrap_evt;
            restart_pulse <= restart_evt;
            err_pulse     <= err_evt;
            if (en) begin
                prev <= cnt_in;
            end
            if (err_evt) begin
                err_sticky <= 1'b1;
            end
        end
    end

`ifdef COUNT_SEQ_ERR_LOG_EN
    // err_sticky still low means this is the first error since reset/clr
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            err_exp <= '0;
            err_act <= '0;
        end else if (err_evt && !err_sticky) begin
            err_exp <= exp_val;
            err_act <= cnt_in;
        end
    end
`endif

    sat_counter #(.W(WRAP_W)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wrap_evt),
        .clr   (clr),
        .count (wrap_count)
    );

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_evt),
        .clr   (clr),
        .count (err_count)
    );

endmodule

// File: tb/tb_count_seq_checker.sv
// tb/tb_count_seq_checker.sv - table-driven and randomized bench for count_seq_checker
module tb_count_seq_checker;

    localparam int LOCK_N = 2;

    logic       clk = 1'b0;
    logic       reset, en, clr;
    logic [3:0] cnt_in;
    logic       wrap_pulse, restart_pulse, err_pulse, err_sticky, locked;
    logic [7:0] wrap_count, err_count;
`ifdef COUNT_SEQ_ERR_LOG_EN
    logic [3:0] err_exp, err_act;
`endif

    count_seq_checker #(.CNT_W(4), .WRAP_W(8), .ERR_W(8), .LOCK_N(LOCK_N)) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .clr           (clr),
        .cnt_in        (cnt_in),
        .wrap_pulse    (wrap_pulse),
        .restart_pulse (restart_pulse),
        .err_pulse     (err_pulse),
        .err_sticky    (err_sticky),
        .wrap_count    (wrap_count),
        .err_count     (err_count),
        .locked        (locked)
`ifdef COUNT_SEQ_ERR_LOG_EN
        ,
        .err_exp       (err_exp),
        .err_act       (err_act)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model: whether a reference sample exists, whether we trust the stream
    bit m_have, m_lock, m_wp, m_rp, m_ep, m_s;
    int m_good, m_prev, m_wc, m_ec, m_lexp, m_lact;

    typedef struct {
        logic       rst, clr, en;
        logic [3:0] cnt;
        logic       w, r, e, l, s;
        int         wc, ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic c, input logic e, input int cnt,
                                input logic xw, input logic xr, input logic xe, input logic xl,
                                input logic xs, input int xwc, input int xec);
        vec_t v;
        v.rst = rst; v.clr = c; v.en = e; v.cnt = 4'(cnt);
        v.w = xw; v.r = xr; v.e = xe; v.l = xl; v.s = xs; v.wc = xwc; v.ec = xec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic c, input logic e, input int v);
        m_wp = 0; m_rp = 0; m_ep = 0;
        if (!r || c) begin
            m_have = 0; m_lock = 0; m_good = 0; m_prev = 0;
            m_wc = 0; m_ec = 0; m_s = 0; m_lexp = 0; m_lact = 0;
        end else if (e) begin
            if (!m_have) begin
                m_have = 1;
                m_lock = 1;
            end else if (v == (m_prev + 1) % 16) begin
                if (m_lock) begin
                    if (m_prev == 15) begin
                        m_wp = 1;
                        m_wc = (m_wc < 255) ? m_wc + 1 : 255;
                    end
                end else begin
                    m_good++;
                    if (m_good >= LOCK_N) m_lock = 1;
                end
            end else if (v == 0) begin
                m_rp = 1;
                if (!m_lock) m_good = 0;
            end else begin
                m_ep = 1;
                m_ec = (m_ec < 255) ? m_ec + 1 : 255;
                if (!m_s) begin
                    m_lexp = (m_prev + 1) % 16;
                    m_lact = v;
                end
                m_s = 1;
                m_lock = 0;
                m_good = 0;
            end
            m_prev = v;
        end
    endtask

    task automatic apply(input logic r, input logic c, input logic e, input int v);
        reset = r; clr = c; en = e; cnt_in = 4'(v);
        model_step(r, c, e, v);
        @(posedge clk);
        #1;
        vectors++;
        chk("wrap_pulse", 32'(wrap_pulse), 32'(m_wp));
        chk("restart_pulse", 32'(restart_pulse), 32'(m_rp));
        chk("err_pulse", 32'(err_pulse), 32'(m_ep));
        chk("err_sticky", 32'(err_sticky), 32'(m_s));
        chk("locked", 32'(locked), 32'(m_lock));
        chk("wrap_count", 32'(wrap_count), 32'(m_wc));
        chk("err_count", 32'(err_count), 32'(m_ec));
`ifdef COUNT_SEQ_ERR_LOG_EN
        chk("err_exp", 32'(err_exp), 32'(m_lexp));
        chk("err_act", 32'(err_act), 32'(m_lact));
`endif
    endtask

    initial begin
        int nwrap;
        int v;
        reset = 0; clr = 0; en = 0; cnt_in = 0;

        // reset state
        apply(0, 0, 0, 0);
        apply(0, 0, 1, 5);
        chk("reset_locked", 32'(locked), 0);
        chk("reset_wrap_count", 32'(wrap_count), 0);

        // ramp 0..15,0..3
        nwrap = 0;
        for (int i = 0; i < 20; i++) begin
            apply(1, 0, 1, i % 16);
            if (i == 0) chk("ramp_first_locked", 32'(locked), 1);
            if (wrap_pulse) nwrap++;
        end
        chk("ramp_wrap_pulses", 32'(nwrap), 1);
        chk("ramp_wrap_count", 32'(wrap_count), 1);
        chk("ramp_err_count", 32'(err_count), 0);

        // directed table: restart, error/relock, clr, hold, en=0, mid-run reset
        tbl.push_back(mk(1,0,1, 4, 0,0,0,1,0, 1,0));
        tbl.push_back(mk(1,0,1, 0, 0,1,0,1,0, 1,0));
        for (int i = 1; i <= 6; i++) tbl.push_back(mk(1,0,1, i, 0,0,0,1,0, 1,0));
        tbl.push_back(mk(1,0,1, 9, 0,0,1,0,1, 1,1));
        tbl.push_back(mk(1,0,1,10, 0,0,0,0,1, 1,1));
        tbl.push_back(mk(1,0,1,11, 0,0,0,1,1, 1,1));
        tbl.push_back(mk(1,1,1, 3, 0,0,0,0,0, 0,0));
        tbl.push_back(mk(1,0,1, 3, 0,0,0,1,0, 0,0));
        tbl.push_back(mk(1,0,1, 3, 0,0,1,0,1, 0,1));
        tbl.push_back(mk(1,0,0, 7, 0,0,0,0,1, 0,1));
        tbl.push_back(mk(1,0,0, 8, 0,0,0,0,1, 0,1));
        tbl.push_back(mk(1,0,0, 1, 0,0,0,0,1, 0,1));
        tbl.push_back(mk(1,0,0, 0, 0,0,0,0,1, 0,1));
        tbl.push_back(mk(1,0,0,15, 0,0,0,0,1, 0,1));
        tbl.push_back(mk(1,0,1, 4, 0,0,0,0,1, 0,1));
        tbl.push_back(mk(1,0,1, 5, 0,0,0,1,1, 0,1));
        tbl.push_back(mk(0,0,1, 6, 0,0,0,0,0, 0,0));
        tbl.push_back(mk(1,0,1, 9, 0,0,0,1,0, 0,0));
        tbl.push_back(mk(1,0,1,10, 0,0,0,1,0, 0,0));
        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].clr, tbl[i].en, int'(tbl[i].cnt));
            chk($sformatf("tbl%0d_wrap_pulse", i), 32'(wrap_pulse), 32'(tbl[i].w));
            chk($sformatf("tbl%0d_restart_pulse", i), 32'(restart_pulse), 32'(tbl[i].r));
            chk($sformatf("tbl%0d_err_pulse", i), 32'(err_pulse), 32'(tbl[i].e));
            chk($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].l));
            chk($sformatf("tbl%0d_err_sticky", i), 32'(err_sticky), 32'(tbl[i].s));
            chk($sformatf("tbl%0d_wrap_count", i), 32'(wrap_count), 32'(tbl[i].wc));
            chk($sformatf("tbl%0d_err_count", i), 32'(err_count), 32'(tbl[i].ec));
        end

        // saturation: more than 300 wraps starting from prev=10
        for (int i = 0; i < 16 * 301; i++) apply(1, 0, 1, (11 + i) % 16);
        chk("sat_wrap_count", 32'(wrap_count), 255);
        apply(1, 1, 0, 0);
        chk("clr_wrap_count", 32'(wrap_count), 0);
        chk("clr_err_count", 32'(err_count), 0);
        chk("clr_err_sticky", 32'(err_sticky), 0);
        chk("clr_locked", 32'(locked), 0);
        apply(1, 0, 0, 4);
        chk("clr_en0_locked", 32'(locked), 0);
        apply(1, 0, 1, 12);
        chk("clr_relock", 32'(locked), 1);

`ifdef COUNT_SEQ_ERR_LOG_EN
        apply(1, 1, 1, 0);
        apply(1, 0, 1, 7);
        apply(1, 0, 1, 12);
        apply(1, 0, 1, 13);
        apply(1, 0, 1, 2);
        chk("log_err_exp", 32'(err_exp), 8);
        chk("log_err_act", 32'(err_act), 12);
`endif

        // randomized stream against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 70)      v = (m_prev + 1) % 16;
            else if (r < 80) v = 0;
            else if (r < 88) v = m_prev;
            else             v = int'($urandom_range(0, 15));
            apply(($urandom_range(0, 99) != 0), ($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) != 0), v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/count_seq_checker.md
# count_seq_checker

Sequence checker that sits directly downstream of the 4-bit up-counter and consumes its `counter` output every clock. It tracks the free-running count, reports each 15→0 wrap, tells a counter restart (return to 0 from a non-terminal value) apart from a genuine sequence error, and keeps saturating wrap and error statistics. It is the self-checking monitor stage for the counter datapath and also drives status to software-visible registers.

## Interface
Parameters:
- `CNT_W`, 4: width of the observed count.
- `WRAP_W`, 8: width of the wrap counter.
- `ERR_W`, 8: width of the error counter.
- `LOCK_N`, 2: consecutive good increments needed to leave FAULT (1..7).

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `en` input 1: sample-enable; when 0 all state holds and pulses are 0.
- `clr` input 1: synchronous clear of statistics and state.
- `cnt_in` input CNT_W: observed counter value.
- `wrap_pulse` output 1: one-cycle pulse when a MAX→0 step is seen in TRACK.
- `restart_pulse` output 1: one-cycle pulse when a non-MAX→0 step is seen.
- `err_pulse` output 1: one-cycle pulse on a sequence error.
- `err_sticky` output 1: set on the first error; held until `clr` or reset.
- `wrap_count` output WRAP_W: saturating wrap count.
- `err_count` output ERR_W: saturating error count.
- `locked` output 1: 1 while the FSM is in TRACK.

## Operation
- MAX = 2^CNT_W−1. `exp` = (`prev` + 1) mod 2^CNT_W, computed at CNT_W bits with natural wrap.
- Priority order: reset, then `clr`, then `en`.
- FSM states: IDLE, TRACK, FAULT.
  - IDLE, en=1: load `prev` = `cnt_in`, go to TRACK. No pulses.
  - TRACK, `cnt_in` == `exp`:
    - If `prev` == MAX: `wrap_pulse`=1 and `wrap_count`++.
    - Stay in TRACK.
  - TRACK, `cnt_in` == 0 and `prev` ≠ MAX: `restart_pulse`=1, stay in TRACK. This is not an error.
  - TRACK, any other value (including a hold, `cnt_in` == `prev`):
    - `err_pulse`=1, `err_count`++, `err_sticky`=1.
    - Go to FAULT and set `good_run` = 0.
  - FAULT, `cnt_in` == `exp`: `good_run`++. When `good_run` reaches LOCK_N, go to TRACK. No wrap is counted in FAULT.
  - FAULT, `cnt_in` == 0 from non-MAX: `restart_pulse`=1, `good_run` = 0.
  - FAULT, any other value: `err_pulse`=1, `err_count`++, `good_run` = 0.
- `prev` loads `cnt_in` on every enabled cycle, in every state, so checking always resynchronises to the latest value.
- Counters saturate: they hold at all-ones and never roll over.
- `clr`: zero both counts, clear `err_sticky`, deassert pulses, go to IDLE.
- Reset values: state IDLE, `prev` 0, `good_run` 0, all outputs 0. `locked` is 0.

## Timing
- All outputs are registered. A pulse is asserted in the cycle after the edge that sampled the triggering `cnt_in`, and lasts exactly one cycle.
- `wrap_count` and `err_count` update on the same edge that raises their pulse.
- `locked` rises on the same edge the FSM enters TRACK:
  - first enabled sample out of reset/`clr` → `locked`=1 one cycle later;
  - after a fault, `locked`=1 on the edge of the LOCK_N-th good step.
- With `en`=0, nothing advances. The next enabled sample is compared against the last enabled sample.
- Reset or `clr` asserted mid-run takes effect on that edge. The cycle after that edge is IDLE, so the next sample is never flagged as an error.

## Configuration
- `COUNT_SEQ_ERR_LOG_EN` defined:
  - Adds outputs `err_exp` [CNT_W] and `err_act` [CNT_W].
  - They capture `exp`/`cnt_in` of the first error after reset/`clr`. Later errors do not overwrite them.
  - Both reset to 0 and are cleared by `clr`.
- Undefined: these ports and their registers are absent. All other behaviour is identical.

## Structure
- Shared package `count_seq_pkg`: state enum (IDLE=2'd0, TRACK=2'd1, FAULT=2'd2) and the default widths.
- One sub-module `sat_counter` (parameter W; inputs inc, clr; output count). It is instantiated twice, for wraps and for errors.
- The FSM, `prev` and `good_run` stay in the top module.

## Test plan
- Reset low for 2 cycles, then feed a 0..15..0..3 ramp with en=1 → `locked`=1 after the first sample; exactly one `wrap_pulse`; `wrap_count`=1; `err_count`=0.
- Feed 0,1,2,3,4 then 0 (counter reset), then 1,2 → one `restart_pulse`; `err_sticky`=0; `locked` stays 1.
- Feed 5,6,9,10,11 → `err_pulse` on the 9 sample; `err_count`=1; `err_sticky`=1; `locked` drops, then returns after the 11 sample (LOCK_N=2).
- Feed 3,3 → the hold is an error; `err_count`=1. Keep `en`=0 for 5 cycles while `cnt_in` changes, then resume with `exp` → no pulses, counts unchanged.
- Drive 300 wraps with WRAP_W=8 → `wrap_count` saturates at 255. Pulse `clr` → counts 0, `err_sticky` 0, `locked` 0, then 1 one cycle after the next enabled sample.
- With `COUNT_SEQ_ERR_LOG_EN`: feed errors 7→12, then 13→2 → `err_exp`=8 and `err_act`=12 (first error retained).
